// File: rtl/video_pkg.sv
// Shared video timing types and helpers for the pixel-domain blocks.
package video_pkg;

  typedef struct packed {
    int unsigned hdisp;
    int unsigned hfp;
    int unsigned hpulse;
    int unsigned hbp;
    int unsigned vdisp;
    int unsigned vfp;
    int unsigned vpulse;
    int unsigned vbp;
  } video_timing_t;

  localparam video_timing_t VT_800X480 = '{
    hdisp: 800, hfp: 40, hpulse: 48, hbp: 40,
    vdisp: 480, vfp: 13, vpulse: 3,  vbp: 29
  };

  function automatic int unsigned line_total(input int unsigned disp, input int unsigned fp,
                                             input int unsigned pulse, input int unsigned bp);
    return disp + fp + pulse + bp;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned total);
    return (total < 2) ? 1 : $clog2(total);
  endfunction

endpackage

// File: rtl/rst_sync.sv
// Reset synchroniser: asserts asynchronously, releases after STAGES rising edges.
module rst_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  output logic rst_out
);

  logic [STAGES-1:0] sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= '1;
    else     sync <= {sync[STAGES-2:0], 1'b0};
  end

  assign rst_out = sync[STAGES-1];

endmodule

// File: rtl/video_timing_gen.sv
// VGA/LCD timing generator: sync/blank/coordinates, run/stop control, line prefetch and frame count.
// Every output is registered from the next x/y so all decodes line up with the x/y they describe.
module video_timing_gen
  import video_pkg::*;
#(
  parameter int unsigned HDISP      = VT_800X480.hdisp,
  parameter int unsigned HFP        = VT_800X480.hfp,
  parameter int unsigned HPULSE     = VT_800X480.hpulse,
  parameter int unsigned HBP        = VT_800X480.hbp,
  parameter int unsigned VDISP      = VT_800X480.vdisp,
  parameter int unsigned VFP        = VT_800X480.vfp,
  parameter int unsigned VPULSE     = VT_800X480.vpulse,
  parameter int unsigned VBP        = VT_800X480.vbp,
  parameter bit          HS_POL     = 1'b0,
  parameter bit          VS_POL     = 1'b0,
  parameter int unsigned RST_STAGES = 2,
  parameter int unsigned PREFETCH   = 16
) (
  input  logic                                                 pixel_clk,
  input  logic                                                 sys_rst,
  input  logic                                                 run,
  output logic                                                 hsync,
  output logic                                                 vsync,
  output logic                                                 blank,
  output logic [cnt_width(line_total(HDISP,HFP,HPULSE,HBP))-1:0] x,
  output logic [cnt_width(line_total(VDISP,VFP,VPULSE,VBP))-1:0] y,
  output logic                                                 frame_start,
  output logic                                                 line_req,
  output logic [15:0]                                          frame_cnt,
  output logic                                                 pixel_rst
);

  localparam int unsigned HTOT = line_total(HDISP, HFP, HPULSE, HBP);
  localparam int unsigned VTOT = line_total(VDISP, VFP, VPULSE, VBP);
  localparam int unsigned HW   = cnt_width(HTOT);
  localparam int unsigned VW   = cnt_width(VTOT);

  localparam logic [HW-1:0] H_ACT    = HW'(HDISP);
  localparam logic [HW-1:0] H_SYNC_S = HW'(HDISP + HFP);
  localparam logic [HW-1:0] H_SYNC_E = HW'(HDISP + HFP + HPULSE);
  localparam logic [HW-1:0] H_LAST   = HW'(HTOT - 1);
  localparam logic [HW-1:0] H_REQ    = HW'(HTOT - PREFETCH);
  localparam logic [VW-1:0] V_ACT    = VW'(VDISP);
  localparam logic [VW-1:0] V_SYNC_S = VW'(VDISP + VFP);
  localparam logic [VW-1:0] V_SYNC_E = VW'(VDISP + VFP + VPULSE);
  localparam logic [VW-1:0] V_LAST   = VW'(VTOT - 1);

  if (HDISP < 1 || HFP < 1 || HPULSE < 1 || HBP < 1 ||
      VDISP < 1 || VFP < 1 || VPULSE < 1 || VBP < 1 ||
      RST_STAGES < 2 || PREFETCH < 1 || PREFETCH > HTOT - HDISP) begin : g_param_check
    $error("video_timing_gen: illegal timing parameters");
  end

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  state_t          state, state_nxt;
  logic [HW-1:0]   x_nxt;
  logic [VW-1:0]   y_nxt, y_after;
  logic            frame_end, active_nxt;

  rst_sync #(.STAGES(RST_STAGES)) u_rst_sync (
    .clk     (pixel_clk),
    .rst     (sys_rst),
    .rst_out (pixel_rst)
  );

  always_comb begin
    state_nxt = state;
    x_nxt     = '0;
    y_nxt     = '0;
    frame_end = (x == H_LAST) && (y == V_LAST);
    case (state)
      IDLE: if (run) state_nxt = RUN;
      RUN, STOP: begin
        x_nxt = (x == H_LAST) ? '0 : x + HW'(1);
        y_nxt = (x != H_LAST) ? y : ((y == V_LAST) ? '0 : y + VW'(1));
        // Halting only takes effect at the frame boundary; run back high resumes without a gap.
        if (frame_end && !run) state_nxt = IDLE;
        else                   state_nxt = run ? RUN : STOP;
      end
      default: state_nxt = IDLE;
    endcase
    active_nxt = (state_nxt != IDLE);
    y_after    = (y_nxt == V_LAST) ? '0 : y_nxt + VW'(1);
  end

  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      state       <= IDLE;
      x           <= '0;
      y           <= '0;
      blank       <= 1'b1;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      frame_start <= 1'b0;
      line_req    <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      state       <= state_nxt;
      x           <= x_nxt;
      y           <= y_nxt;
      blank       <= !(active_nxt && x_nxt < H_ACT && y_nxt < V_ACT);
      hsync       <= (active_nxt && x_nxt >= H_SYNC_S && x_nxt < H_SYNC_E) ? HS_POL : ~HS_POL;
      vsync       <= (active_nxt && y_nxt >= V_SYNC_S && y_nxt < V_SYNC_E) ? VS_POL : ~VS_POL;
      frame_start <= active_nxt && x_nxt == '0 && y_nxt == '0;
      line_req    <= active_nxt && x_nxt == H_REQ && y_after < V_ACT;
      frame_cnt   <= frame_cnt + 16'((state != IDLE) && frame_end);
    end
  end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Parametrised VGA/LCD timing generator in the pixel_clk domain, in front of the vga pixel FIFO read side.
- Generates sync, blank and pixel coordinates from per-parameter porch and pulse widths, with selectable sync polarity.
- Provides a start/stop control, a line prefetch request for the SDRAM reader, and a frame counter.
- Includes its own N-stage reset synchroniser: sys_rst is the only reset input.

Parameters:
- HDISP, 800, active pixels per line
- HFP, 40, horizontal front porch (cycles)
- HPULSE, 48, horizontal sync pulse width
- HBP, 40, horizontal back porch
- VDISP, 480, active lines per frame
- VFP, 13, vertical front porch (lines)
- VPULSE, 3, vertical sync width
- VBP, 29, vertical back porch
- HS_POL, 0, active level of hsync (0 = active-low)
- VS_POL, 0, active level of vsync
- RST_STAGES, 2, reset synchroniser depth (>= 2)
- PREFETCH, 16, cycles before line start at which line_req fires (1..HTOT-HDISP)

Ports:
- pixel_clk  in  1  pixel clock
- sys_rst  in  1  reset: asynchronous, active-high
- run  in  1  level; 1 = generate frames, 0 = halt at next frame boundary
- hsync  out  1  horizontal sync, polarity HS_POL
- vsync  out  1  vertical sync, polarity VS_POL
- blank  out  1  1 outside the active area
- x  out  HW  horizontal counter, HW = $clog2(HTOT)
- y  out  VW  vertical counter, VW = $clog2(VTOT)
- frame_start  out  1  one-cycle pulse when x=0, y=0
- line_req  out  1  one-cycle prefetch pulse for the next active line
- frame_cnt  out  16  completed frames, wraps at 0xFFFF to 0
- pixel_rst  out  1  synchronised reset exported to other pixel-domain logic

Behaviour:
- Totals: HTOT = HDISP+HFP+HPULSE+HBP; VTOT = VDISP+VFP+VPULSE+VBP.
- Reset synchroniser: RST_STAGES flops, asynchronously set by sys_rst.
  - Deassertion shifts in 0; pixel_rst falls on the RST_STAGES-th rising edge after sys_rst falls.
  - sys_rst asserted mid-frame: pixel_rst rises immediately (asynchronously); all state returns to reset values.
- While pixel_rst=1, outputs are:
  - x=0, y=0, blank=1, hsync=!HS_POL, vsync=!VS_POL
  - frame_start=0, line_req=0, frame_cnt=0, internal state=IDLE
- Horizontal regions (x):
  - active: x < HDISP
  - front porch: HDISP..HDISP+HFP-1
  - sync: HDISP+HFP..HDISP+HFP+HPULSE-1
  - back porch: remainder up to HTOT-1
- Vertical regions (y): same layout with the V parameters.
- Counters: x increments every cycle in RUN. At x=HTOT-1, x wraps to 0 and y increments; at y=VTOT-1, y wraps to 0.
- All outputs are registers updated on the same edge. hsync, vsync, blank, frame_start and line_req decode the x,y values output in the same cycle, with zero skew between them.
- blank = !(x<HDISP && y<VDISP).
- hsync is active while x is in the H sync region, on every line. vsync is active while y is in the V sync region, for whole lines.
- frame_start = (x==0 && y==0) in RUN.
- frame_cnt increments in the cycle after x=HTOT-1, y=VTOT-1 (frame completion).
- line_req = 1 when x == HTOT-PREFETCH and the next line (y+1, wrapping VTOT-1 to 0) is < VDISP. Exactly VDISP pulses per frame.
- FSM states:
  - IDLE: counters held at 0, outputs at reset values. Go to RUN when run=1, with first cycle x=0, y=0, frame_start=1.
  - RUN: counting. If run=0, go to STOP (frame finishes normally).
  - STOP: keep counting. If run returns to 1 before the frame ends, go back to RUN (no gap). At the wrap from x=HTOT-1, y=VTOT-1, go to IDLE (x=0, y=0, blank=1, no frame_start) and frame_cnt still increments.
- run toggled during IDLE→RUN transition: sampled once per cycle, no glitch protection needed.
- Parameter legality enforced by an elaboration-time assertion: all widths >= 1, PREFETCH in range.

Decomposition:
- Shared package video_pkg: video_timing_t struct (h/v disp, fp, pulse, bp); the 800x480 default constant; localparam function computing totals and counter widths.
- vga and the mire generator import video_pkg for HDISP/VDISP.
- One sub-module: rst_sync (parameter STAGES), reusable for sys_clk-domain resets.
- FSM state enum is local to this module.

Test Plan:
(Small config unless stated: HDISP=8, HFP=2, HPULSE=3, HBP=3 (HTOT=16); VDISP=4, VFP=1, VPULSE=2, VBP=1 (VTOT=8); one frame = 128 cycles.)
- Reset release, RST_STAGES=3: sys_rst falls between edges -> pixel_rst low exactly at the 3rd rising edge; outputs stay at reset values until then.
- run=1 held, HS_POL=0: hsync=0 for x=10..12 on every line; blank=0 only for x<8 and y<4; frame_start every 128 cycles; frame_cnt=3 after 3 frames.
- VS_POL=1: vsync=1 exactly for y=5..6 (32 cycles per frame), aligned with x=0 of y=5.
- PREFETCH=4: line_req at x=12 for y=7, 0, 1, 2 only; 4 pulses per frame; none for y=3..6.
- run dropped at y=2 -> frame completes; then x=0, y=0, blank=1 held, frame_cnt incremented once. run re-raised -> frame_start in the cycle after. run dropped and re-raised within a frame -> no gap.
- sys_rst pulsed for 1 ns at x=5, y=2 -> pixel_rst asserts immediately; x, y, frame_cnt return to 0; restart after RST_STAGES edges.
